// File: rtl/spi_master.sv
// spi_master: single-transaction SPI master.
// Frames an ADDRESS_WIDTH-bit address followed by a DATA_WIDTH-bit data phase
// under one SS assertion. Supports all CPOL/CPHA modes and a programmable SCK
// half-period divider.
// Optional build macro SPI_LSB_FIRST_EN: address and data each travel LSB
// first, and the received word is mirrored back so it round-trips unchanged.
module spi_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    data,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     enable,
    input  logic                     rd_we,
    input  logic [15:0]              divider,
    input  logic                     clock_phase,
    input  logic                     clock_polarity,
    input  logic                     MISO,
    output logic                     SCK,
    output logic [DATA_WIDTH-1:0]    data_read,
    output logic                     busy,
    output logic                     SS,
    output logic                     MOSI,
    output logic                     data_read_valid
);

    localparam int N  = ADDRESS_WIDTH + DATA_WIDTH;
    localparam int EW = $clog2(2 * N + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * N - 1);

    typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

    state_t                state, state_next;
    logic [15:0]           cnt;
    logic [15:0]           div_q;
    logic [EW-1:0]         edge_cnt;
    logic [N-1:0]          sr;
    logic [N-1:0]          tx_word;
    logic [DATA_WIDTH-1:0] rx;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  cpha_q;
    logic                  rd_q;
    logic                  start;
    logic                  period_done;
    logic                  sck_tick;
    logic                  sample_edge;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic [ADDRESS_WIDTH-1:0] rev_addr(input logic [ADDRESS_WIDTH-1:0] v);
        logic [ADDRESS_WIDTH-1:0] r;
        for (int i = 0; i < ADDRESS_WIDTH; i++) r[i] = v[ADDRESS_WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
        return r;
    endfunction

    // Frame words with each field bit-reversed so the MSB-first shifter sends LSB first.
    always_comb begin
        tx_word = {rev_addr(address), rd_we ? {DATA_WIDTH{1'b0}} : rev_data(data)};
        rx_word = rev_data(rx);
    end
`else
    // Frame words in natural order; reads send zeros in the data phase.
    always_comb begin
        tx_word = {address, rd_we ? {DATA_WIDTH{1'b0}} : data};
        rx_word = rx;
    end
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-cycle timing strobes.
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        period_done = (cnt == div_q - 16'd1);
        sck_tick    = 1'b0;
        // Even-numbered edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
        sample_edge = ~edge_cnt[0] ^ cpha_q;
        case (state)
            IDLE: begin
                if (enable) begin
                    start      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (period_done) state_next = TRANSFER;
            end
            TRANSFER: begin
                sck_tick = period_done;
                if (period_done && edge_cnt == LAST_EDGE) state_next = HOLD;
            end
            HOLD: begin
                if (period_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: divider counter, SCK generation, shift registers and outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt             <= '0;
            div_q           <= 16'd1;
            edge_cnt        <= '0;
            sr              <= '0;
            rx              <= '0;
            cpha_q          <= 1'b0;
            rd_q            <= 1'b0;
            SCK             <= 1'b0;
            SS              <= 1'b1;
            MOSI            <= 1'b0;
            busy            <= 1'b0;
            data_read       <= '0;
            data_read_valid <= 1'b0;
        end else begin
            data_read_valid <= 1'b0;

            if (state == IDLE || period_done) cnt <= '0;
            else                              cnt <= cnt + 16'd1;

            case (state)
                IDLE: begin
                    SCK  <= clock_polarity;
                    SS   <= 1'b1;
                    MOSI <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        div_q    <= (divider == 16'd0) ? 16'd1 : divider;
                        cpha_q   <= clock_phase;
                        rd_q     <= rd_we;
                        edge_cnt <= '0;
                        rx       <= '0;
                        busy     <= 1'b1;
                        SS       <= 1'b0;
                        if (clock_phase) begin
                            // CPHA=1: first bit goes out on the first leading edge.
                            sr   <= tx_word;
                            MOSI <= 1'b0;
                        end else begin
                            // CPHA=0: first bit must be valid as SS falls.
                            sr   <= {tx_word[N-2:0], 1'b0};
                            MOSI <= tx_word[N-1];
                        end
                    end
                end
                TRANSFER: begin
                    if (sck_tick) begin
                        SCK      <= ~SCK;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (sample_edge) begin
                            rx <= {rx[DATA_WIDTH-2:0], MISO};
                        end else begin
                            MOSI <= sr[N-1];
                            sr   <= {sr[N-2:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (period_done) begin
                        SS   <= 1'b1;
                        busy <= 1'b0;
                        MOSI <= 1'b0;
                        if (rd_q) begin
                            data_read       <= rx_word;
                            data_read_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master with a
// mode-aware SPI slave model.
module tb_spi_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = '0;
    logic [31:0] address = '0;
    logic        enable = 1'b0;
    logic        rd_we = 1'b0;
    logic [15:0] divider = 16'd1;
    logic        clock_phase = 1'b0;
    logic        clock_polarity = 1'b0;
    logic        MISO = 1'b0;
    logic        SCK;
    logic [31:0] data_read;
    logic        busy;
    logic        SS;
    logic        MOSI;
    logic        data_read_valid;

    int vectors = 0;
    int miscompares = 0;

    // Slave model state
    logic        s_cpol = 1'b0;
    logic        s_cpha = 1'b0;
    logic [63:0] s_tx = '0;
    logic [63:0] s_rx = '0;
    int          m_idx = 0;
    logic        ss_prev = 1'b1;
    logic        sck_prev = 1'b0;

    spi_master #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .data(data), .address(address),
        .enable(enable), .rd_we(rd_we), .divider(divider),
        .clock_phase(clock_phase), .clock_polarity(clock_polarity),
        .MISO(MISO), .SCK(SCK), .data_read(data_read), .busy(busy),
        .SS(SS), .MOSI(MOSI), .data_read_valid(data_read_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ord(input logic [31:0] v);
`ifdef SPI_LSB_FIRST_EN
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
`else
        return v;
`endif
    endfunction

    task automatic slave_drive();
        if (m_idx < 64) MISO = s_tx[63-m_idx];
        else            MISO = 1'b0;
        m_idx++;
    endtask

    // SPI slave: drives MISO on its shift edge, captures MOSI on its sample edge.
    always @(SS or SCK) begin
        if (ss_prev && !SS) begin
            s_rx  = '0;
            m_idx = 0;
            if (!s_cpha) slave_drive();
        end else if (!SS && SCK !== sck_prev) begin
            if ((SCK != s_cpol) ^ s_cpha) s_rx = {s_rx[62:0], MOSI};
            else                          slave_drive();
        end
        ss_prev  = SS;
        sck_prev = SCK;
    end

    task automatic run(input string tag, input logic cpol, input logic cpha,
                       input logic [15:0] d, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic rd,
                       input logic [31:0] miso_data, input int en_hold,
                       input int repulse_at, output int busy_o);
        int   dd, busy_cnt, edges, gmin, gmax, valid_cnt, valid_bad, last_edge, extra;
        logic prev_sck, prev_busy, seen, done;
        logic [63:0] exp_frame;
        dd = (d == 16'd0) ? 1 : int'(d);
        @(negedge clock);
        clock_polarity = cpol; clock_phase = cpha; divider = d;
        address = addr; data = wdata; rd_we = rd;
        s_cpol = cpol; s_cpha = cpha;
        s_tx = {32'hC3C3_0FF0, ord(miso_data)};
        repeat (2) @(negedge clock);
        check({tag, ".idle_sck_before"}, SCK, cpol);
        busy_cnt = 0; edges = 0; gmin = 1000000; gmax = 0; valid_cnt = 0; valid_bad = 0;
        last_edge = -1; prev_sck = SCK; prev_busy = busy; seen = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            enable = (cyc < en_hold) || (cyc == repulse_at);
            if (busy) busy_cnt++;
            if (SCK !== prev_sck && busy) begin
                edges++;
                if (last_edge >= 0) begin
                    if (cyc - last_edge < gmin) gmin = cyc - last_edge;
                    if (cyc - last_edge > gmax) gmax = cyc - last_edge;
                end
                last_edge = cyc;
            end
            if (data_read_valid) begin
                valid_cnt++;
                if (busy || !prev_busy) valid_bad++;
            end
            if (busy) seen = 1'b1;
            if (seen && !busy) done = 1'b1;
            prev_sck = SCK; prev_busy = busy;
            if (!done) @(negedge clock);
        end
        enable = 1'b0;
        busy_o = busy_cnt;
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".busy_cycles"}, busy_cnt, dd * (2 + 2 * 64));
        check({tag, ".sck_edges"}, edges, 128);
        check({tag, ".gap_min"}, gmin, dd);
        check({tag, ".gap_max"}, gmax, dd);
        check({tag, ".idle_sck_after"}, SCK, cpol);
        check({tag, ".ss_after"}, SS, 1'b1);
        exp_frame = rd ? {ord(addr), 32'h0} : {ord(addr), ord(wdata)};
        check({tag, ".slave_rx"}, s_rx, exp_frame);
        check({tag, ".valid_cnt"}, valid_cnt, rd ? 1 : 0);
        check({tag, ".valid_align"}, valid_bad, 0);
        if (rd) check({tag, ".data_read"}, data_read, miso_data);
        extra = 0;
        repeat (20) begin
            @(negedge clock);
            if (busy) extra++;
        end
        check({tag, ".no_retrigger"}, extra, 0);
    endtask

    initial begin
        int b;
        int sck_changes;
        logic last;

        // Reset held from time zero
        repeat (3) @(negedge clock);
        check("rst0.sck", SCK, 1'b0);
        check("rst0.ss", SS, 1'b1);
        check("rst0.mosi", MOSI, 1'b0);
        check("rst0.busy", busy, 1'b0);
        check("rst0.valid", data_read_valid, 1'b0);
        check("rst0.data_read", data_read, 32'h0);
        reset = 1'b0;

        // Async reset while idle with CPOL=1 pulls SCK low immediately
        clock_polarity = 1'b1;
        repeat (3) @(negedge clock);
        check("idle.sck_tracks_cpol", SCK, 1'b1);
        #2 reset = 1'b1;
        #1 check("rst_idle.sck", SCK, 1'b0);
        check("rst_idle.ss", SS, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        clock_polarity = 1'b0;

        // Mode 0 write, D=2
        run("wr_m0", 1'b0, 1'b0, 16'd2, 32'h8000_0010, 32'hA5A5_A5A5, 1'b0, 32'h0, 1, -1, b);
        check("wr_m0.busy260", b, 260);

        // Mode 3 read, D=1
        run("rd_m3", 1'b1, 1'b1, 16'd1, 32'h0000_0044, 32'hFFFF_FFFF, 1'b1, 32'h3C5A_F00F, 1, -1, b);
        check("rd_m3.busy130", b, 130);

        // All four modes, D=3, writes
        for (int m = 0; m < 4; m++) begin
            run($sformatf("wr_mode%0d", m), m[1], m[0], 16'd3, 32'h0BAD_CAFE,
                32'h1234_5678, 1'b0, 32'h0, 1, -1, b);
        end
        check("data_read_hold", data_read, 32'h3C5A_F00F);

        // Enable held 10 cycles and re-pulsed mid-transfer: exactly one transaction
        run("en_hold", 1'b0, 1'b1, 16'd1, 32'h0000_00F1, 32'h5555_AAAA, 1'b0, 32'h0, 10, 100, b);

        // divider=0 behaves as divider=1
        run("div0", 1'b1, 1'b0, 16'd0, 32'hFEDC_BA98, 32'h0F0F_1234, 1'b1, 32'h8000_0001, 1, -1, b);
        check("div0.busy130", b, 130);

        // Reset mid-transfer during a read
        @(negedge clock);
        clock_polarity = 1'b0; clock_phase = 1'b0; divider = 16'd2; rd_we = 1'b1;
        s_cpol = 1'b0; s_cpha = 1'b0;
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        repeat (50) @(negedge clock);
        check("rst_mid.busy_before", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid.sck", SCK, 1'b0);
        check("rst_mid.ss", SS, 1'b1);
        check("rst_mid.mosi", MOSI, 1'b0);
        check("rst_mid.busy", busy, 1'b0);
        check("rst_mid.valid", data_read_valid, 1'b0);
        check("rst_mid.data_read", data_read, 32'h0);
        sck_changes = 0;
        last = SCK;
        repeat (5) begin
            @(negedge clock);
            if (SCK !== last) sck_changes++;
            last = SCK;
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (SCK !== last) sck_changes++;
            if (data_read_valid) sck_changes++;
            last = SCK;
        end
        check("rst_mid.no_edges", sck_changes, 0);
        check("rst_mid.busy_after", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
